// File: rtl/sonic_loopback_ctrl.sv
// PMA loopback mode controller with drain/settle sequencing and a
// 40-bit counting-pattern generator and checker.
module sonic_loopback_ctrl #(
    parameter int DRAIN_CYCLES  = 16,
    parameter int SETTLE_CYCLES = 32
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_mode,
    output logic        req_ready,
    input  logic        test_en,
    input  logic [39:0] rx_data,
    output logic        loopback_en,
    output logic [39:0] tx_pattern,
    output logic        pattern_sel,
    output logic        busy,
    output logic [2:0]  state,
    output logic        done,
    output logic        lock,
    output logic [15:0] err_cnt
);

    localparam int CMAX = (DRAIN_CYCLES > SETTLE_CYCLES) ? DRAIN_CYCLES : SETTLE_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] DRAIN_LD  = CW'(DRAIN_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_DRAIN       = 3'd1,
        S_SWITCH      = 3'd2,
        S_SETTLE      = 3'd3,
        S_ACTIVE      = 3'd4,
        S_EXIT_DRAIN  = 3'd5,
        S_EXIT_SETTLE = 3'd6
    } state_e;

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic          loopback_q;
    logic          done_q;
    logic [39:0]   gen_q;
    logic [39:0]   prev_q;
    logic [39:0]   exp_q;
    logic [2:0]    match_q;
    logic          lock_q;
    logic [15:0]   err_q;

    logic idle_or_active;
    logic gen_window;
    logic chk_en;
    logic active_entry;

    assign idle_or_active = (state_q == S_IDLE) || (state_q == S_ACTIVE);
    assign gen_window     = (state_q == S_SETTLE) || (state_q == S_ACTIVE);
    assign chk_en         = (state_q == S_ACTIVE) && test_en;
    assign active_entry   = (state_q == S_SETTLE) && (cnt_q == '0);

    assign req_ready   = idle_or_active;
    assign busy        = !idle_or_active;
    assign state       = state_q;
    assign done        = done_q;
    assign loopback_en = loopback_q;
    assign pattern_sel = gen_window && test_en;
    assign tx_pattern  = pattern_sel ? gen_q : 40'd0;
    assign lock        = lock_q;
    assign err_cnt     = err_q;

    // Sequencer: shared down-counter times every drain/settle phase.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            loopback_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        if (req_mode) begin
                            state_q <= S_DRAIN;
                            cnt_q   <= DRAIN_LD;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (cnt_q == '0) begin
                        state_q    <= S_SWITCH;
                        loopback_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                S_SWITCH: begin
                    state_q <= S_SETTLE;
                    cnt_q   <= SETTLE_LD;
                end
                S_SETTLE: begin
                    if (cnt_q == '0) begin
                        state_q <= S_ACTIVE;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                S_ACTIVE: begin
                    if (req_valid) begin
                        if (!req_mode) begin
                            state_q <= S_EXIT_DRAIN;
                            cnt_q   <= DRAIN_LD;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                S_EXIT_DRAIN: begin
                    if (cnt_q == '0) begin
                        state_q    <= S_EXIT_SETTLE;
                        cnt_q      <= SETTLE_LD;
                        loopback_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                S_EXIT_SETTLE: begin
                    if (cnt_q == '0) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    cnt_q      <= '0;
                    loopback_q <= 1'b0;
                end
            endcase
        end
    end

    // Pattern generator restarts at zero each time SETTLE is entered.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            gen_q <= '0;
        end else if (state_q == S_SWITCH) begin
            gen_q <= '0;
        end else if (gen_window && test_en) begin
            gen_q <= gen_q + 40'd1;
        end
    end

    // Checker: acquire on consecutive counting words, then track expected.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            prev_q  <= '0;
            exp_q   <= '0;
            match_q <= '0;
            lock_q  <= 1'b0;
        end else begin
            prev_q <= rx_data;
            if (!chk_en) begin
                lock_q  <= 1'b0;
                match_q <= '0;
            end else if (!lock_q) begin
                if (match_q == 3'd4) begin
                    lock_q  <= 1'b1;
                    exp_q   <= rx_data + 40'd1;
                    match_q <= '0;
                end else if (rx_data == prev_q + 40'd1) begin
                    match_q <= match_q + 3'd1;
                end else begin
                    match_q <= '0;
                end
            end else begin
                exp_q <= exp_q + 40'd1;
            end
        end
    end

    // Error counter: cleared on ACTIVE entry, saturates, held after exit.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            err_q <= '0;
        end else if (active_entry) begin
            err_q <= '0;
        end else if (chk_en && lock_q && (rx_data != exp_q) && (err_q != 16'hFFFF)) begin
            err_q <= err_q + 16'd1;
        end
    end

endmodule

// File: tb/tb_sonic_loopback_ctrl.sv
// Directed testbench for sonic_loopback_ctrl: sequencing, pattern
// generator, checker lock/errors/saturation and reset behaviour.
module tb_sonic_loopback_ctrl;

    logic        clk_in = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_mode;
    logic        req_ready;
    logic        test_en;
    logic [39:0] rx_data;
    logic        loopback_en;
    logic [39:0] tx_pattern;
    logic        pattern_sel;
    logic        busy;
    logic [2:0]  state;
    logic        done;
    logic        lock;
    logic [15:0] err_cnt;

    logic [39:0] d1 = '0;
    logic [39:0] d2 = '0;
    logic [39:0] d3 = '0;
    logic [39:0] corrupt = '0;
    logic [39:0] rx_manual = '0;
    logic        man_en = 1'b0;

    int checks = 0;
    int errors = 0;

    sonic_loopback_ctrl dut (
        .clk_in      (clk_in),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_mode    (req_mode),
        .req_ready   (req_ready),
        .test_en     (test_en),
        .rx_data     (rx_data),
        .loopback_en (loopback_en),
        .tx_pattern  (tx_pattern),
        .pattern_sel (pattern_sel),
        .busy        (busy),
        .state       (state),
        .done        (done),
        .lock        (lock),
        .err_cnt     (err_cnt)
    );

    always #5 clk_in = ~clk_in;

    // three-cycle loopback channel model
    always @(posedge clk_in) begin
        d1 <= tx_pattern;
        d2 <= d1;
        d3 <= d2;
    end

    assign rx_data = man_en ? rx_manual : (d3 ^ corrupt);

    task automatic tick;
        @(posedge clk_in);
        #1;
    endtask

    task automatic go_enter(output bit ok);
        int n;
        req_valid = 1'b1;
        req_mode  = 1'b1;
        tick();
        req_valid = 1'b0;
        n = 0;
        while (state != 3'd4 && n < 200) begin
            n++;
            tick();
        end
        ok = (state == 3'd4);
    endtask

    task automatic go_exit(output bit ok);
        int n;
        req_valid = 1'b1;
        req_mode  = 1'b0;
        tick();
        req_valid = 1'b0;
        n = 0;
        while (state != 3'd0 && n < 200) begin
            n++;
            tick();
        end
        ok = (state == 3'd0);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        req_valid = 1'b0;
        req_mode = 1'b0;
        test_en = 1'b0;
        tick();
        tick();
        checks++;
        if (state !== 3'd0) begin
            errors++;
            $display("FAIL reset_state: got %0d expected 0", state);
        end
        checks++;
        if ({loopback_en, pattern_sel, busy, done, lock} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {loopback_en, pattern_sel, busy, done, lock});
        end
        checks++;
        if (tx_pattern !== 40'd0 || err_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_data: got tx=%0h err=%0h expected 0 0", tx_pattern, err_cnt);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b expected 1", req_ready);
        end
    endtask

    task automatic test_noop_idle;
        req_valid = 1'b1;
        req_mode = 1'b0;
        tick();
        req_valid = 1'b0;
        checks++;
        if (done !== 1'b1 || state !== 3'd0) begin
            errors++;
            $display("FAIL noop_idle: got done=%b state=%0d expected 1 0", done, state);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL noop_pulse: got done=%b expected 0", done);
        end
    endtask

    task automatic test_enter;
        int n;
        int m;
        test_en = 1'b1;
        req_valid = 1'b1;
        req_mode = 1'b1;
        tick();
        req_valid = 1'b0;
        checks++;
        if (state !== 3'd1 || busy !== 1'b1 || req_ready !== 1'b0 || loopback_en !== 1'b0) begin
            errors++;
            $display("FAIL enter_drain: got st=%0d busy=%b rdy=%b lb=%b expected 1 1 0 0",
                     state, busy, req_ready, loopback_en);
        end
        n = 0;
        while (state == 3'd1 && n < 100) begin
            req_valid = (n == 5);
            req_mode = 1'b0;
            if (n == 3) begin
                checks++;
                if (pattern_sel !== 1'b0 || tx_pattern !== 40'd0) begin
                    errors++;
                    $display("FAIL drain_pattern: got sel=%b tx=%0h expected 0 0",
                             pattern_sel, tx_pattern);
                end
            end
            n++;
            tick();
        end
        req_valid = 1'b0;
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL drain_len: got %0d expected 16", n);
        end
        checks++;
        if (state !== 3'd2 || loopback_en !== 1'b1) begin
            errors++;
            $display("FAIL switch: got st=%0d lb=%b expected 2 1", state, loopback_en);
        end
        tick();
        checks++;
        if (state !== 3'd3 || tx_pattern !== 40'd0 || pattern_sel !== 1'b1) begin
            errors++;
            $display("FAIL settle_entry: got st=%0d tx=%0h sel=%b expected 3 0 1",
                     state, tx_pattern, pattern_sel);
        end
        tick();
        checks++;
        if (tx_pattern !== 40'd1) begin
            errors++;
            $display("FAIL gen_inc: got %0h expected 1", tx_pattern);
        end
        m = 1;
        while (state == 3'd3 && m < 100) begin
            m++;
            tick();
        end
        checks++;
        if (m != 32 || (n + 1 + m) != 49) begin
            errors++;
            $display("FAIL settle_len: got settle=%0d total=%0d expected 32 49", m, n + 1 + m);
        end
        checks++;
        if (state !== 3'd4 || done !== 1'b1 || loopback_en !== 1'b1) begin
            errors++;
            $display("FAIL active_entry: got st=%0d done=%b lb=%b expected 4 1 1",
                     state, done, loopback_en);
        end
    endtask

    task automatic test_clean_loop;
        int k;
        int bad;
        k = 0;
        while (lock !== 1'b1 && k < 20) begin
            k++;
            tick();
        end
        checks++;
        if (lock !== 1'b1 || k > 5) begin
            errors++;
            $display("FAIL lock_time: got lock=%b after %0d cycles expected 1 within 5", lock, k);
        end
        bad = 0;
        repeat (1000) begin
            tick();
            if (err_cnt !== 16'd0) bad++;
        end
        checks++;
        if (bad != 0 || lock !== 1'b1) begin
            errors++;
            $display("FAIL clean_loop: got bad=%0d lock=%b expected 0 1", bad, lock);
        end
    endtask

    task automatic test_errors;
        repeat (3) begin
            corrupt = 40'h1;
            tick();
            corrupt = 40'h0;
            repeat (3) tick();
        end
        checks++;
        if (err_cnt !== 16'd3 || lock !== 1'b1) begin
            errors++;
            $display("FAIL err3: got err=%0d lock=%b expected 3 1", err_cnt, lock);
        end
        man_en = 1'b1;
        rx_manual = 40'd0;
        repeat (70000) tick();
        checks++;
        if (err_cnt !== 16'hFFFF || lock !== 1'b1) begin
            errors++;
            $display("FAIL err_sat: got err=%0h lock=%b expected ffff 1", err_cnt, lock);
        end
    endtask

    task automatic test_exit;
        int n;
        int m;
        req_valid = 1'b1;
        req_mode = 1'b0;
        tick();
        req_valid = 1'b0;
        checks++;
        if (state !== 3'd5 || loopback_en !== 1'b1) begin
            errors++;
            $display("FAIL exit_drain: got st=%0d lb=%b expected 5 1", state, loopback_en);
        end
        n = 0;
        while (state == 3'd5 && n < 100) begin
            n++;
            tick();
        end
        checks++;
        if (n != 16 || state !== 3'd6 || loopback_en !== 1'b0) begin
            errors++;
            $display("FAIL exit_switch: got n=%0d st=%0d lb=%b expected 16 6 0", n, state, loopback_en);
        end
        m = 0;
        while (state == 3'd6 && m < 100) begin
            m++;
            tick();
        end
        checks++;
        if (m != 32 || state !== 3'd0 || done !== 1'b1) begin
            errors++;
            $display("FAIL exit_idle: got m=%0d st=%0d done=%b expected 32 0 1", m, state, done);
        end
        checks++;
        if (err_cnt !== 16'hFFFF || lock !== 1'b0) begin
            errors++;
            $display("FAIL exit_hold: got err=%0h lock=%b expected ffff 0", err_cnt, lock);
        end
    endtask

    task automatic test_wrap;
        bit ok;
        logic [39:0] base;
        test_en = 1'b0;
        man_en = 1'b1;
        rx_manual = 40'd0;
        go_enter(ok);
        checks++;
        if (!ok || err_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reenter: got ok=%b err=%0h expected 1 0", ok, err_cnt);
        end
        checks++;
        if (pattern_sel !== 1'b0 || tx_pattern !== 40'd0) begin
            errors++;
            $display("FAIL test_off: got sel=%b tx=%0h expected 0 0", pattern_sel, tx_pattern);
        end
        test_en = 1'b1;
        base = 40'hFF_FFFF_FFF8;
        for (int i = 0; i < 24; i++) begin
            rx_manual = base + 40'(i);
            tick();
        end
        checks++;
        if (lock !== 1'b1 || err_cnt !== 16'd0) begin
            errors++;
            $display("FAIL wrap: got lock=%b err=%0h expected 1 0", lock, err_cnt);
        end
        go_exit(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wrap_exit: got state=%0d expected 0", state);
        end
    endtask

    task automatic test_reset_mid;
        int n;
        int bad;
        test_en = 1'b1;
        man_en = 1'b0;
        req_valid = 1'b1;
        req_mode = 1'b1;
        tick();
        req_valid = 1'b0;
        n = 0;
        while (state != 3'd3 && n < 100) begin
            n++;
            tick();
        end
        repeat (4) tick();
        checks++;
        if (state !== 3'd3 || loopback_en !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: got st=%0d lb=%b expected 3 1", state, loopback_en);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (loopback_en !== 1'b0 || state !== 3'd0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got lb=%b st=%0d busy=%b done=%b expected 0 0 0 0",
                     loopback_en, state, busy, done);
        end
        tick();
        tick();
        reset = 1'b0;
        bad = 0;
        repeat (60) begin
            tick();
            if (done !== 1'b0 || state !== 3'd0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_abandon: got %0d bad cycles expected 0", bad);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_noop_idle();
        test_enter();
        test_clean_loop();
        test_errors();
        test_exit();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
